// File: rtl/psram_req_bridge_pkg.sv
// Shared types and constants for the PSRAM request bridge.
package a2pdp_pkg;

  // Bridge sequencer states.
  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_WR_CMD  = 3'd2,
    ST_RD_CMD  = 3'd3,
    ST_RD_WAIT = 3'd4
  } bridge_state_t;

  // Byte-lane enables, bit1 = high byte.
  localparam logic [1:0] WMASK_WORD = 2'b11;
  localparam logic [1:0] WMASK_LO   = 2'b01;
  localparam logic [1:0] WMASK_HI   = 2'b10;

  // Data returned to the bus when a read is abandoned.
  localparam logic [15:0] RDATA_ABORT = 16'hFFFF;

  // Lane mask for a write: full word, or the lane picked by byte address bit 0.
  function automatic logic [1:0] lane_mask(input logic is_byte, input logic a0);
    if (!is_byte) begin
      return WMASK_WORD;
    end
    return a0 ? WMASK_HI : WMASK_LO;
  endfunction

endpackage

// File: rtl/psram_req_bridge_if.sv
// Command/response port between the bridge and the PSRAM controller.
interface psram_req_bridge_if #(
  parameter int MEM_AW = 21
);
  logic              mem_calib;
  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_cmd_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [1:0]        mem_wmask;
  logic              mem_rvalid;
  logic [15:0]       mem_rdata;

  // Bridge side: issues commands, consumes read data.
  modport master (
    input  mem_calib, mem_cmd_ready, mem_rvalid, mem_rdata,
    output mem_cmd_valid, mem_cmd_we, mem_addr, mem_wdata, mem_wmask
  );

  // Controller side.
  modport slave (
    output mem_calib, mem_cmd_ready, mem_rvalid, mem_rdata,
    input  mem_cmd_valid, mem_cmd_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/psram_req_bridge_slot.sv
// Single-entry request holding register. A "fresh" flag marks contents the
// sequencer has not yet copied into its command registers; a clear is only
// honoured when the entry is not fresh, so a request that overwrote the slot
// while its predecessor was in flight is not lost.
module req_slot
  import a2pdp_pkg::*;
#(
  parameter int AW = 21
) (
  input  logic          clk_x3,
  input  logic          rstb,
  input  logic          i_set,
  input  logic [AW-1:0] i_addr,
  input  logic [15:0]   i_wdata,
  input  logic [1:0]    i_wmask,
  input  logic          i_take,
  input  logic          i_clr,
  output logic          o_valid,
  output logic [AW-1:0] o_addr,
  output logic [15:0]   o_wdata,
  output logic [1:0]    o_wmask,
  output logic          o_overrun
);

  logic          r_valid;
  logic          r_fresh;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_wdata;
  logic [1:0]    r_wmask;
  logic          w_clr_eff;

  assign w_clr_eff = i_clr & ~r_fresh;
  // A set onto a full slot is an overrun unless the slot empties this cycle.
  assign o_overrun = i_set & r_valid & ~w_clr_eff;

  // Set wins over clear and take; data is captured only on set.
  always_ff @(posedge clk_x3) begin
    if (rstb) begin
      r_valid <= 1'b0;
      r_fresh <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (i_set) begin
      r_valid <= 1'b1;
      r_fresh <= 1'b1;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
      r_wmask <= i_wmask;
    end else begin
      if (w_clr_eff) r_valid <= 1'b0;
      if (i_take)    r_fresh <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_wmask = r_wmask;

endmodule

// File: rtl/psram_req_bridge.sv
// Turns DCJ11 RAM strobe levels into single PSRAM controller commands,
// holding one pending write and one pending read, and returns read data.
module psram_req_bridge
  import a2pdp_pkg::*;
#(
  parameter int MEM_AW  = 21,
  parameter int TIMEOUT = 63
) (
  input  logic                clk_x3,
  input  logic                rstb,
  input  logic [MEM_AW:0]     ram_addr,
  input  logic [15:0]         ram_wdata,
  input  logic                ram_read,
  input  logic                ram_write,
  input  logic                ram_byte,
  output logic [15:0]         ram_rdata,
  output logic                init,
  output logic                busy,
  output logic                err_timeout,
  output logic                err_overrun,
  psram_req_bridge_if.master  mem
);

  localparam int CW = $clog2(TIMEOUT + 1);

  bridge_state_t     r_state, w_state_next;
  logic              r_rd_prev, r_wr_prev, r_rd_edge, r_wr_edge;
  logic [CW-1:0]     r_cnt;
  logic              r_init, r_err_to, r_err_ov;
  logic [15:0]       r_rdata;
  logic              r_cmd_we;
  logic [MEM_AW-1:0] r_cmd_addr;
  logic [15:0]       r_cmd_wdata;
  logic [1:0]        r_cmd_wmask;

  logic              w_wr_valid, w_rd_valid, w_wr_ovr, w_rd_ovr;
  logic [MEM_AW-1:0] w_wr_addr, w_rd_addr;
  logic [15:0]       w_wr_wdata, w_rd_wdata;
  logic [1:0]        w_wr_wmask, w_rd_wmask, w_wmask;
  logic              w_take_wr, w_take_rd, w_clr_wr, w_rd_done, w_rd_abort, w_cnt_last;

  assign w_wmask = lane_mask(ram_byte, ram_addr[0]);

  // Edge detect: the registered pulse marks a sampled 0->1 of each strobe.
  always_ff @(posedge clk_x3) begin
    if (rstb) begin
      r_rd_prev <= 1'b0;
      r_wr_prev <= 1'b0;
      r_rd_edge <= 1'b0;
      r_wr_edge <= 1'b0;
    end else begin
      r_rd_prev <= ram_read;
      r_wr_prev <= ram_write;
      r_rd_edge <= ram_read & ~r_rd_prev;
      r_wr_edge <= ram_write & ~r_wr_prev;
    end
  end

  req_slot #(.AW(MEM_AW)) u_wr_slot (
    .clk_x3    (clk_x3),
    .rstb      (rstb),
    .i_set     (r_wr_edge),
    .i_addr    (ram_addr[MEM_AW:1]),
    .i_wdata   (ram_wdata),
    .i_wmask   (w_wmask),
    .i_take    (w_take_wr),
    .i_clr     (w_clr_wr),
    .o_valid   (w_wr_valid),
    .o_addr    (w_wr_addr),
    .o_wdata   (w_wr_wdata),
    .o_wmask   (w_wr_wmask),
    .o_overrun (w_wr_ovr)
  );

  req_slot #(.AW(MEM_AW)) u_rd_slot (
    .clk_x3    (clk_x3),
    .rstb      (rstb),
    .i_set     (r_rd_edge),
    .i_addr    (ram_addr[MEM_AW:1]),
    .i_wdata   (ram_wdata),
    .i_wmask   (WMASK_WORD),
    .i_take    (w_take_rd),
    .i_clr     (w_rd_done | w_rd_abort),
    .o_valid   (w_rd_valid),
    .o_addr    (w_rd_addr),
    .o_wdata   (w_rd_wdata),
    .o_wmask   (w_rd_wmask),
    .o_overrun (w_rd_ovr)
  );

  // Every action below is gated by calibration so a calib drop only ever
  // moves the FSM back to INIT, keeping slots for re-issue.
  assign w_cnt_last = (r_cnt == CW'(TIMEOUT - 1));
  assign w_take_wr  = mem.mem_calib && (r_state == ST_IDLE) && w_wr_valid;
  assign w_take_rd  = mem.mem_calib && (r_state == ST_IDLE) && !w_wr_valid && w_rd_valid;
  assign w_clr_wr   = mem.mem_calib && (r_state == ST_WR_CMD) && mem.mem_cmd_ready;
  assign w_rd_done  = mem.mem_calib && (r_state == ST_RD_WAIT) && mem.mem_rvalid;
  assign w_rd_abort = mem.mem_calib && (r_state == ST_RD_WAIT) && !mem.mem_rvalid && w_cnt_last;

  // Next-state selection; write wins over read because it came first on the bus.
  always_comb begin
    w_state_next = r_state;
    if (!mem.mem_calib) begin
      w_state_next = ST_INIT;
    end else begin
      case (r_state)
        ST_INIT:    w_state_next = ST_IDLE;
        ST_IDLE: begin
          if (w_wr_valid)      w_state_next = ST_WR_CMD;
          else if (w_rd_valid) w_state_next = ST_RD_CMD;
        end
        ST_WR_CMD:  if (mem.mem_cmd_ready) w_state_next = ST_IDLE;
        ST_RD_CMD:  if (mem.mem_cmd_ready) w_state_next = ST_RD_WAIT;
        ST_RD_WAIT: if (w_rd_done || w_rd_abort) w_state_next = ST_IDLE;
        default:    w_state_next = ST_INIT;
      endcase
    end
  end

  // State register and RD_WAIT cycle counter.
  always_ff @(posedge clk_x3) begin
    if (rstb) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_RD_WAIT) r_cnt <= r_cnt + CW'(1);
      else                       r_cnt <= '0;
    end
  end

  // Command registers load once when leaving IDLE so they stay fixed while valid.
  always_ff @(posedge clk_x3) begin
    if (rstb) begin
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cmd_wmask <= '0;
    end else if (w_take_wr) begin
      r_cmd_we    <= 1'b1;
      r_cmd_addr  <= w_wr_addr;
      r_cmd_wdata <= w_wr_wdata;
      r_cmd_wmask <= w_wr_wmask;
    end else if (w_take_rd) begin
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= w_rd_addr;
      r_cmd_wdata <= w_rd_wdata;
      r_cmd_wmask <= w_rd_wmask;
    end
  end

  // Read data hold, sticky error flags and registered calibration status.
  always_ff @(posedge clk_x3) begin
    if (rstb) begin
      r_rdata  <= '0;
      r_err_to <= 1'b0;
      r_err_ov <= 1'b0;
      r_init   <= 1'b0;
    end else begin
      r_init <= mem.mem_calib;
      if (w_rd_done)       r_rdata <= mem.mem_rdata;
      else if (w_rd_abort) r_rdata <= RDATA_ABORT;
      if (w_rd_abort)          r_err_to <= 1'b1;
      if (w_wr_ovr || w_rd_ovr) r_err_ov <= 1'b1;
    end
  end

  assign mem.mem_cmd_valid = (r_state == ST_WR_CMD) || (r_state == ST_RD_CMD);
  assign mem.mem_cmd_we    = r_cmd_we;
  assign mem.mem_addr      = r_cmd_addr;
  assign mem.mem_wdata     = r_cmd_wdata;
  assign mem.mem_wmask     = r_cmd_wmask;

  assign ram_rdata   = r_rdata;
  assign init        = r_init;
  // INIT is waiting, not working: only active states or pending requests count.
  assign busy        = ((r_state != ST_IDLE) && (r_state != ST_INIT)) || w_wr_valid || w_rd_valid;
  assign err_timeout = r_err_to;
  assign err_overrun = r_err_ov;

endmodule
